// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I core front end.
package riscv_pkg;

  // Canonical bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  // Address of the first instruction fetched after reset
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Fetch controller states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Build the IF/ID entry that represents "no instruction"
  function automatic ifid_t make_bubble(input logic [31:0] nop);
    ifid_t b;
    b.pc       = 32'h0000_0000;
    b.pc_plus4 = 32'h0000_0000;
    b.instr    = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: holds when en=0, loads a bubble or the fetched entry.
module ifid_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_reg;

  // Reset to a bubble; otherwise update only when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= make_bubble(NOP_INSTR);
    end else if (en) begin
      if (bubble) begin
        q_reg <= make_bubble(NOP_INSTR);
      end else begin
        q_reg <= d;
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address, fills IF/ID,
// and applies stalls, EX redirects and fetch-fault halting.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_VECTOR,
  parameter int          IMEM_WORDS = 4096,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] RedirectPC,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemInstr,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus4,
  output logic [31:0] IfIdInstr,
  output logic        IfIdValid,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  // One past the last legal byte address; 33 bits so a 4 GiB ROM still compares
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         fault_reg, fault_next;
  logic [31:0]  count_reg, count_next;

  logic         ifid_en;
  logic         ifid_bubble;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  logic [31:0]  pc_plus4;
  logic         pc_out_of_range;
  logic         redirect_misaligned;

  assign pc_plus4            = pc_reg + 32'd4;
  assign pc_out_of_range     = ({1'b0, pc_reg} >= PC_LIMIT);
  assign redirect_misaligned = (RedirectPC[1:0] != 2'b00);

  // Entry presented to IF/ID when a real fetch completes
  always_comb begin
    ifid_d          = make_bubble(NOP_INSTR);
    ifid_d.pc       = pc_reg;
    ifid_d.pc_plus4 = pc_plus4;
    ifid_d.instr    = ImemInstr;
    ifid_d.valid    = 1'b1;
  end

  // State, PC, fault and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
      count_reg <= 32'h0000_0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  // Next-state, next-PC and IF/ID control; redirect outranks stall,
  // stall outranks the range check
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    fault_next  = fault_reg;
    count_next  = count_reg;
    ifid_en     = 1'b1;
    ifid_bubble = 1'b1;

    case (state_reg)
      BOOT: begin
        // Single settling cycle; Stall and Flush have no effect here
        state_next = RUN;
      end

      RUN: begin
        if (Flush && redirect_misaligned) begin
          state_next = HALT;
          fault_next = 1'b1;
        end else if (Flush) begin
          pc_next = RedirectPC;
        end else if (Stall) begin
          ifid_en = 1'b0;
        end else if (pc_out_of_range) begin
          state_next = HALT;
          fault_next = 1'b1;
        end else begin
          ifid_bubble = 1'b0;
          count_next  = count_reg + 32'd1;
          pc_next     = pc_plus4;
        end
      end

      HALT: begin
        // Frozen until reset; keep feeding bubbles downstream
        fault_next = 1'b1;
      end

      default: begin
        state_next = HALT;
        fault_next = 1'b1;
      end
    endcase
  end

  ifid_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .en     (ifid_en),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ImemAddr    = pc_reg;
  assign IfIdPC      = ifid_q.pc;
  assign IfIdPCPlus4 = ifid_q.pc_plus4;
  assign IfIdInstr   = ifid_q.instr;
  assign IfIdValid   = ifid_q.valid;
  assign FetchFault  = fault_reg;
  assign FetchCount  = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a full-size instance for stall/flush/fault
// scenarios and a 4-word instance for the out-of-range halt.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic        s_rst;
  logic [31:0] s_imem_addr;
  logic [31:0] s_imem_instr;
  logic [31:0] s_ifid_pc;
  logic [31:0] s_ifid_pc_plus4;
  logic [31:0] s_ifid_instr;
  logic        s_ifid_valid;
  logic        s_fetch_fault;
  logic [31:0] s_fetch_count;

  int checks;
  int errors;

  // ROM model: every word is distinct and encodes its own address
  function automatic logic [31:0] rom(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  assign imem_instr   = rom(imem_addr);
  assign s_imem_instr = rom(s_imem_addr);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (stall),
    .Flush       (flush),
    .RedirectPC  (redirect_pc),
    .ImemAddr    (imem_addr),
    .ImemInstr   (imem_instr),
    .IfIdPC      (ifid_pc),
    .IfIdPCPlus4 (ifid_pc_plus4),
    .IfIdInstr   (ifid_instr),
    .IfIdValid   (ifid_valid),
    .FetchFault  (fetch_fault),
    .FetchCount  (fetch_count)
  );

  fetch_stage #(.IMEM_WORDS(4)) dut_small (
    .clk         (clk),
    .rst         (s_rst),
    .Stall       (1'b0),
    .Flush       (1'b0),
    .RedirectPC  (32'h0000_0000),
    .ImemAddr    (s_imem_addr),
    .ImemInstr   (s_imem_instr),
    .IfIdPC      (s_ifid_pc),
    .IfIdPCPlus4 (s_ifid_pc_plus4),
    .IfIdInstr   (s_ifid_instr),
    .IfIdValid   (s_ifid_valid),
    .FetchFault  (s_fetch_fault),
    .FetchCount  (s_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    s_rst       = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 32'h0;

    // Reset values
    tick();
    check("rst_valid", ifid_valid, 0);
    check("rst_instr", ifid_instr, 32'h13);
    check("rst_pc", ifid_pc, 0);
    check("rst_pc4", ifid_pc_plus4, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_count", fetch_count, 0);
    $display("reset: addr=%h valid=%0d count=%0d", imem_addr, ifid_valid, fetch_count);

    // T1: BOOT bubble then free-running fetch
    rst = 1'b0;
    tick();
    check("t1_boot_valid", ifid_valid, 0);
    check("t1_boot_addr", imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_pc", ifid_pc, 32'(i * 4));
      check("t1_pc4", ifid_pc_plus4, 32'(i * 4 + 4));
      check("t1_instr", ifid_instr, rom(32'(i * 4)));
      check("t1_valid", ifid_valid, 1);
      $display("t1 fetch: pc=%h instr=%h count=%0d", ifid_pc, ifid_instr, fetch_count);
    end
    check("t1_count", fetch_count, 4);

    // Restart so the stall lands with PC=8 and IfIdPC=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("t2_pre_addr", imem_addr, 32'h8);

    // T2: three stall cycles hold everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_pc", ifid_pc, 32'h4);
      check("t2_hold_addr", imem_addr, 32'h8);
      check("t2_hold_count", fetch_count, 2);
      $display("t2 stall: addr=%h ifid_pc=%h count=%0d", imem_addr, ifid_pc, fetch_count);
    end
    stall = 1'b0;
    tick();
    check("t2_release_pc", ifid_pc, 32'h8);
    check("t2_release_count", fetch_count, 3);

    // T3: redirect with concurrent stall; flush wins
    flush       = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h40;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    check("t3_bubble_valid", ifid_valid, 0);
    check("t3_bubble_instr", ifid_instr, 32'h13);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_bubble_count", fetch_count, 3);
    tick();
    check("t3_target_pc", ifid_pc, 32'h40);
    check("t3_target_instr", ifid_instr, rom(32'h40));
    check("t3_target_valid", ifid_valid, 1);
    check("t3_count", fetch_count, 4);
    $display("t3 redirect: ifid_pc=%h instr=%h", ifid_pc, ifid_instr);

    // T4: misaligned redirect halts
    flush       = 1'b1;
    redirect_pc = 32'h42;
    tick();
    flush = 1'b0;
    check("t4_fault", fetch_fault, 1);
    check("t4_valid", ifid_valid, 0);
    check("t4_addr", imem_addr, 32'h44);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_halt_addr", imem_addr, 32'h44);
      check("t4_halt_valid", ifid_valid, 0);
      check("t4_halt_fault", fetch_fault, 1);
      check("t4_halt_count", fetch_count, 4);
    end
    $display("t4 halt: addr=%h fault=%0d count=%0d", imem_addr, fetch_fault, fetch_count);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_addr", imem_addr, 0);
    check("t4_rst_fault", fetch_fault, 0);

    // T6: reset mid-run with a concurrent flush
    tick();
    tick();
    tick();
    check("t6_pre_pc", ifid_pc, 32'h4);
    rst         = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'h80;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check("t6_rst_addr", imem_addr, 0);
    check("t6_rst_valid", ifid_valid, 0);
    check("t6_rst_instr", ifid_instr, 32'h13);
    check("t6_rst_pc", ifid_pc, 0);
    check("t6_rst_count", fetch_count, 0);
    check("t6_rst_fault", fetch_fault, 0);
    tick();
    check("t6_boot_valid", ifid_valid, 0);
    tick();
    check("t6_first_pc", ifid_pc, 0);
    check("t6_first_valid", ifid_valid, 1);
    $display("t6 reset: first ifid_pc=%h count=%0d", ifid_pc, fetch_count);

    // T5: 4-word ROM runs off the end
    tick();
    s_rst = 1'b0;
    tick();
    check("t5_boot_valid", s_ifid_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_pc", s_ifid_pc, 32'(i * 4));
      check("t5_fault_run", s_fetch_fault, 0);
    end
    check("t5_count_pre", s_fetch_count, 4);
    check("t5_addr_pre", s_imem_addr, 32'h10);
    tick();
    check("t5_fault", s_fetch_fault, 1);
    check("t5_valid", s_ifid_valid, 0);
    check("t5_count", s_fetch_count, 4);
    tick();
    check("t5_hold_addr", s_imem_addr, 32'h10);
    check("t5_hold_count", s_fetch_count, 4);
    $display("t5 range: addr=%h fault=%0d count=%0d", s_imem_addr, s_fetch_fault, s_fetch_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
